// File: rtl/rs_alu_pkg.sv
// Shared widths, opcode encoding and entry types for the ALU/branch reservation station.
// The operand snoop helper is shared by the wakeup path and the dispatch bypass.
package rs_alu_pkg;

  localparam int unsigned RsSize = 16;
  localparam int unsigned IdxW   = 4;
  localparam int unsigned NickW  = 4;
  localparam int unsigned DataW  = 32;
  localparam int unsigned OpW    = 6;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned ImmW   = 32;

  // Opcode encoding shared with the execute unit.
  localparam logic [OpW-1:0] OpAdd   = 6'd0;
  localparam logic [OpW-1:0] OpSub   = 6'd1;
  localparam logic [OpW-1:0] OpAnd   = 6'd2;
  localparam logic [OpW-1:0] OpOr    = 6'd3;
  localparam logic [OpW-1:0] OpXor   = 6'd4;
  localparam logic [OpW-1:0] OpSll   = 6'd5;
  localparam logic [OpW-1:0] OpSrl   = 6'd6;
  localparam logic [OpW-1:0] OpSra   = 6'd7;
  localparam logic [OpW-1:0] OpSlt   = 6'd8;
  localparam logic [OpW-1:0] OpSltu  = 6'd9;
  localparam logic [OpW-1:0] OpAddi  = 6'd10;
  localparam logic [OpW-1:0] OpAndi  = 6'd11;
  localparam logic [OpW-1:0] OpOri   = 6'd12;
  localparam logic [OpW-1:0] OpXori  = 6'd13;
  localparam logic [OpW-1:0] OpSlti  = 6'd14;
  localparam logic [OpW-1:0] OpSltiu = 6'd15;
  localparam logic [OpW-1:0] OpLui   = 6'd16;
  localparam logic [OpW-1:0] OpAuipc = 6'd17;
  localparam logic [OpW-1:0] OpBeq   = 6'd20;
  localparam logic [OpW-1:0] OpBne   = 6'd21;
  localparam logic [OpW-1:0] OpBlt   = 6'd22;
  localparam logic [OpW-1:0] OpBge   = 6'd23;
  localparam logic [OpW-1:0] OpBltu  = 6'd24;
  localparam logic [OpW-1:0] OpBgeu  = 6'd25;
  localparam logic [OpW-1:0] OpJal   = 6'd26;
  localparam logic [OpW-1:0] OpJalr  = 6'd27;

  typedef struct packed {
    logic             rdy;
    logic [NickW-1:0] nick;
    logic [DataW-1:0] val;
  } operand_t;

  typedef struct packed {
    logic [AddrW-1:0] pc;
    logic [OpW-1:0]   op;
    logic [ImmW-1:0]  imm;
    logic [NickW-1:0] rd_nick;
    operand_t         src1;
    operand_t         src2;
  } entry_t;

  // A waiting operand captures a matching broadcast; the execute bus wins a tag tie.
  function automatic operand_t snoop(operand_t         o,
                                     logic             ex_en,
                                     logic [NickW-1:0] ex_nick,
                                     logic [DataW-1:0] ex_dt,
                                     logic             slb_en,
                                     logic [NickW-1:0] slb_nick,
                                     logic [DataW-1:0] slb_dt);
    operand_t r;
    r = o;
    if (!o.rdy) begin
      if (ex_en && (ex_nick == o.nick)) begin
        r.rdy = 1'b1;
        r.val = ex_dt;
      end else if (slb_en && (slb_nick == o.nick)) begin
        r.rdy = 1'b1;
        r.val = slb_dt;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_alu_if.sv
// Dispatch, result-broadcast, flush and issue signals of the ALU reservation station.
// master drives dispatch/broadcast/flush and consumes issue; slave is the station.
interface rs_alu_if;
  import rs_alu_pkg::*;

  logic             dp_en;
  logic [AddrW-1:0] dp_pc;
  logic [OpW-1:0]   dp_op;
  logic [ImmW-1:0]  dp_imm;
  logic [NickW-1:0] dp_rd_nick;
  logic             dp_rs1_rdy;
  logic [DataW-1:0] dp_rs1_dt;
  logic [NickW-1:0] dp_rs1_nick;
  logic             dp_rs2_rdy;
  logic [DataW-1:0] dp_rs2_dt;
  logic [NickW-1:0] dp_rs2_nick;
  logic             rs_full;

  logic             ex_en;
  logic [NickW-1:0] ex_nick;
  logic [DataW-1:0] ex_dt;
  logic             slb_en;
  logic [NickW-1:0] slb_nick;
  logic [DataW-1:0] slb_dt;
  logic             rob_clr;

  logic             rs_en;
  logic [AddrW-1:0] rs_pc;
  logic [OpW-1:0]   rs_op;
  logic [ImmW-1:0]  rs_imm;
  logic [NickW-1:0] rs_rd_nick;
  logic [DataW-1:0] rs_rs1_dt;
  logic [DataW-1:0] rs_rs2_dt;

  modport master (
    output dp_en, dp_pc, dp_op, dp_imm, dp_rd_nick,
    output dp_rs1_rdy, dp_rs1_dt, dp_rs1_nick, dp_rs2_rdy, dp_rs2_dt, dp_rs2_nick,
    output ex_en, ex_nick, ex_dt, slb_en, slb_nick, slb_dt, rob_clr,
    input  rs_full, rs_en, rs_pc, rs_op, rs_imm, rs_rd_nick, rs_rs1_dt, rs_rs2_dt
  );

  modport slave (
    input  dp_en, dp_pc, dp_op, dp_imm, dp_rd_nick,
    input  dp_rs1_rdy, dp_rs1_dt, dp_rs1_nick, dp_rs2_rdy, dp_rs2_dt, dp_rs2_nick,
    input  ex_en, ex_nick, ex_dt, slb_en, slb_nick, slb_dt, rob_clr,
    output rs_full, rs_en, rs_pc, rs_op, rs_imm, rs_rd_nick, rs_rs1_dt, rs_rs2_dt
  );

endinterface

// File: rtl/rs_alu_select.sv
// Priority pickers: lowest-index free entry for dispatch, lowest-index ready entry for issue.
module rs_alu_select #(
  parameter int unsigned N    = 16,
  parameter int unsigned IdxW = 4
) (
  input  logic [N-1:0]    busy_i,
  input  logic [N-1:0]    ready_i,
  output logic [IdxW-1:0] free_idx_o,
  output logic            free_vld_o,
  output logic [IdxW-1:0] iss_idx_o,
  output logic            iss_vld_o
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    free_idx_o = '0;
    free_vld_o = 1'b0;
    iss_idx_o  = '0;
    iss_vld_o  = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        free_idx_o = IdxW'(i);
        free_vld_o = 1'b1;
      end
      if (ready_i[i]) begin
        iss_idx_o = IdxW'(i);
        iss_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU/branch reservation station: holds renamed micro-ops, wakes operands from the result
// buses and issues the lowest-index operand-complete entry, at most one per cycle.
module rs_alu
  import rs_alu_pkg::*;
(
  input logic     clk_i,
  input logic     rst_ni,
  input logic     rdy_i,
  rs_alu_if.slave bus
);

  logic [RsSize-1:0] busy_q, busy_d;
  logic [RsSize-1:0] ready;
  entry_t            ent_q [RsSize];
  entry_t            ent_d [RsSize];

  logic [IdxW-1:0]   free_idx, iss_idx;
  logic              free_vld, iss_vld;
  logic              full;
  logic              issue;
  operand_t          src1_in, src2_in;

  logic              out_en_q, out_en_d;
  logic [AddrW-1:0]  out_pc_q, out_pc_d;
  logic [OpW-1:0]    out_op_q, out_op_d;
  logic [ImmW-1:0]   out_imm_q, out_imm_d;
  logic [NickW-1:0]  out_rd_q, out_rd_d;
  logic [DataW-1:0]  out_v1_q, out_v1_d;
  logic [DataW-1:0]  out_v2_q, out_v2_d;

  always_comb begin
    for (int i = 0; i < int'(RsSize); i++) begin
      ready[i] = busy_q[i] & ent_q[i].src1.rdy & ent_q[i].src2.rdy;
    end
  end

  rs_alu_select #(
    .N   (RsSize),
    .IdxW(IdxW)
  ) u_select (
    .busy_i    (busy_q),
    .ready_i   (ready),
    .free_idx_o(free_idx),
    .free_vld_o(free_vld),
    .iss_idx_o (iss_idx),
    .iss_vld_o (iss_vld)
  );

  assign full    = &busy_q;
  assign issue   = iss_vld & ~bus.rob_clr;
  assign src1_in = '{rdy: bus.dp_rs1_rdy, nick: bus.dp_rs1_nick, val: bus.dp_rs1_dt};
  assign src2_in = '{rdy: bus.dp_rs2_rdy, nick: bus.dp_rs2_nick, val: bus.dp_rs2_dt};

  always_comb begin
    busy_d    = busy_q;
    ent_d     = ent_q;
    out_en_d  = 1'b0;
    out_pc_d  = out_pc_q;
    out_op_d  = out_op_q;
    out_imm_d = out_imm_q;
    out_rd_d  = out_rd_q;
    out_v1_d  = out_v1_q;
    out_v2_d  = out_v2_q;

    for (int i = 0; i < int'(RsSize); i++) begin
      if (busy_q[i]) begin
        ent_d[i].src1 = snoop(ent_q[i].src1, bus.ex_en, bus.ex_nick, bus.ex_dt,
                              bus.slb_en, bus.slb_nick, bus.slb_dt);
        ent_d[i].src2 = snoop(ent_q[i].src2, bus.ex_en, bus.ex_nick, bus.ex_dt,
                              bus.slb_en, bus.slb_nick, bus.slb_dt);
      end
    end

    // Issue reads start-of-cycle state; the issued entry's operands are already ready.
    if (issue) begin
      busy_d[iss_idx] = 1'b0;
      out_en_d        = 1'b1;
      out_pc_d        = ent_q[iss_idx].pc;
      out_op_d        = ent_q[iss_idx].op;
      out_imm_d       = ent_q[iss_idx].imm;
      out_rd_d        = ent_q[iss_idx].rd_nick;
      out_v1_d        = ent_q[iss_idx].src1.val;
      out_v2_d        = ent_q[iss_idx].src2.val;
    end

    if (bus.dp_en && !full && free_vld) begin
      busy_d[free_idx]         = 1'b1;
      ent_d[free_idx].pc       = bus.dp_pc;
      ent_d[free_idx].op       = bus.dp_op;
      ent_d[free_idx].imm      = bus.dp_imm;
      ent_d[free_idx].rd_nick  = bus.dp_rd_nick;
      ent_d[free_idx].src1     = snoop(src1_in, bus.ex_en, bus.ex_nick, bus.ex_dt,
                                       bus.slb_en, bus.slb_nick, bus.slb_dt);
      ent_d[free_idx].src2     = snoop(src2_in, bus.ex_en, bus.ex_nick, bus.ex_dt,
                                       bus.slb_en, bus.slb_nick, bus.slb_dt);
    end

    if (bus.rob_clr) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= '0;
      ent_q     <= '{default: '0};
      out_en_q  <= 1'b0;
      out_pc_q  <= '0;
      out_op_q  <= '0;
      out_imm_q <= '0;
      out_rd_q  <= '0;
      out_v1_q  <= '0;
      out_v2_q  <= '0;
    end else if (rdy_i) begin
      busy_q    <= busy_d;
      ent_q     <= ent_d;
      out_en_q  <= out_en_d;
      out_pc_q  <= out_pc_d;
      out_op_q  <= out_op_d;
      out_imm_q <= out_imm_d;
      out_rd_q  <= out_rd_d;
      out_v1_q  <= out_v1_d;
      out_v2_q  <= out_v2_d;
    end
  end

  assign bus.rs_full    = full;
  assign bus.rs_en      = out_en_q;
  assign bus.rs_pc      = out_pc_q;
  assign bus.rs_op      = out_op_q;
  assign bus.rs_imm     = out_imm_q;
  assign bus.rs_rd_nick = out_rd_q;
  assign bus.rs_rs1_dt  = out_v1_q;
  assign bus.rs_rs2_dt  = out_v2_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed scenarios plus randomized traffic against a slot-array model of the station.
module tb_rs_alu;
  import rs_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic rdy = 1'b1;
  bit   chk_on = 1'b0;

  rs_alu_if bus ();

  rs_alu dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .rdy_i (rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one slot per entry, filled lowest-free-first, drained lowest-ready-first.
  bit          mb  [16];
  logic [31:0] mpc [16];
  logic [5:0]  mop [16];
  logic [31:0] mimm[16];
  logic [3:0]  mrd [16];
  bit          mr1 [16];
  bit          mr2 [16];
  logic [3:0]  mn1 [16];
  logic [3:0]  mn2 [16];
  logic [31:0] mv1 [16];
  logic [31:0] mv2 [16];
  bit          m_en;
  logic [31:0] m_pc, m_imm, m_v1, m_v2;
  logic [5:0]  m_op;
  logic [3:0]  m_rd;

  function automatic bit m_full();
    for (int i = 0; i < 16; i++) if (!mb[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [32:0] woken(bit r, logic [3:0] n, logic [31:0] v);
    if (r) return {1'b1, v};
    if (bus.ex_en && bus.ex_nick == n) return {1'b1, bus.ex_dt};
    if (bus.slb_en && bus.slb_nick == n) return {1'b1, bus.slb_dt};
    return {1'b0, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mb[i] = 1'b0;
    m_en = 0; m_pc = 0; m_op = 0; m_imm = 0; m_rd = 0; m_v1 = 0; m_v2 = 0;
  endtask

  task automatic model_step();
    int iss = -1;
    int fr = -1;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    if (!rdy) return;
    if (bus.rob_clr) begin
      for (int i = 0; i < 16; i++) mb[i] = 1'b0;
      m_en = 0;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (iss < 0 && mb[i] && mr1[i] && mr2[i]) iss = i;
      if (fr < 0 && !mb[i]) fr = i;
    end
    for (int i = 0; i < 16; i++) begin
      if (mb[i]) begin
        {mr1[i], mv1[i]} = woken(mr1[i], mn1[i], mv1[i]);
        {mr2[i], mv2[i]} = woken(mr2[i], mn2[i], mv2[i]);
      end
    end
    m_en = (iss >= 0);
    if (iss >= 0) begin
      m_pc = mpc[iss]; m_op = mop[iss]; m_imm = mimm[iss]; m_rd = mrd[iss];
      m_v1 = mv1[iss]; m_v2 = mv2[iss];
      mb[iss] = 1'b0;
    end
    if (bus.dp_en && fr >= 0) begin
      mb[fr] = 1'b1; mpc[fr] = bus.dp_pc; mop[fr] = bus.dp_op; mimm[fr] = bus.dp_imm;
      mrd[fr] = bus.dp_rd_nick; mn1[fr] = bus.dp_rs1_nick; mn2[fr] = bus.dp_rs2_nick;
      {mr1[fr], mv1[fr]} = woken(bus.dp_rs1_rdy, bus.dp_rs1_nick, bus.dp_rs1_dt);
      {mr2[fr], mv2[fr]} = woken(bus.dp_rs2_rdy, bus.dp_rs2_nick, bus.dp_rs2_dt);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_en", 32'(bus.rs_en), 32'(m_en));
      chk("cmp_full", 32'(bus.rs_full), 32'(m_full()));
      chk("cmp_pc", bus.rs_pc, m_pc);
      chk("cmp_op", 32'(bus.rs_op), 32'(m_op));
      chk("cmp_imm", bus.rs_imm, m_imm);
      chk("cmp_rd", 32'(bus.rs_rd_nick), 32'(m_rd));
      chk("cmp_rs1", bus.rs_rs1_dt, m_v1);
      chk("cmp_rs2", bus.rs_rs2_dt, m_v2);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.dp_en = 0; bus.dp_pc = 0; bus.dp_op = 0; bus.dp_imm = 0; bus.dp_rd_nick = 0;
    bus.dp_rs1_rdy = 0; bus.dp_rs1_dt = 0; bus.dp_rs1_nick = 0;
    bus.dp_rs2_rdy = 0; bus.dp_rs2_dt = 0; bus.dp_rs2_nick = 0;
    bus.ex_en = 0; bus.ex_nick = 0; bus.ex_dt = 0;
    bus.slb_en = 0; bus.slb_nick = 0; bus.slb_dt = 0;
    bus.rob_clr = 0;
  endtask

  task automatic disp(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                      input logic [3:0] rd, input bit r1, input logic [31:0] v1,
                      input logic [3:0] n1, input bit r2, input logic [31:0] v2,
                      input logic [3:0] n2);
    bus.dp_en = 1; bus.dp_pc = pc; bus.dp_op = op; bus.dp_imm = imm; bus.dp_rd_nick = rd;
    bus.dp_rs1_rdy = r1; bus.dp_rs1_dt = v1; bus.dp_rs1_nick = n1;
    bus.dp_rs2_rdy = r2; bus.dp_rs2_dt = v2; bus.dp_rs2_nick = n2;
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    chk("reset_en", 32'(bus.rs_en), 32'd0);
    chk("reset_full", 32'(bus.rs_full), 32'd0);
    chk("reset_pc", bus.rs_pc, 32'd0);
    chk("reset_rs1", bus.rs_rs1_dt, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    chk_on = 1'b1;

    // Both operands ready: issue one edge after dispatch.
    disp(32'h100, OpAdd, 32'h0, 4'd3, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0);
    tick(); idle();
    chk("add_not_yet", 32'(bus.rs_en), 32'd0);
    tick();
    chk("add_en", 32'(bus.rs_en), 32'd1);
    chk("add_op", 32'(bus.rs_op), 32'(OpAdd));
    chk("add_rs1", bus.rs_rs1_dt, 32'd5);
    chk("add_rs2", bus.rs_rs2_dt, 32'd7);
    chk("add_rd", 32'(bus.rs_rd_nick), 32'd3);
    chk("add_pc", bus.rs_pc, 32'h100);
    tick();
    chk("add_drop", 32'(bus.rs_en), 32'd0);

    // rs1 waits on nick 2, woken by the execute bus two cycles later.
    disp(32'h200, OpBeq, 32'h10, 4'd4, 0, 32'd0, 4'd2, 1, 32'h11, 4'd0);
    tick(); idle();
    tick();
    chk("beq_wait1", 32'(bus.rs_en), 32'd0);
    bus.ex_en = 1; bus.ex_nick = 4'd2; bus.ex_dt = 32'h55;
    tick(); idle();
    chk("beq_wait2", 32'(bus.rs_en), 32'd0);
    tick();
    chk("beq_en", 32'(bus.rs_en), 32'd1);
    chk("beq_rs1", bus.rs_rs1_dt, 32'h55);
    chk("beq_rd", 32'(bus.rs_rd_nick), 32'd4);
    tick();

    // Same-cycle bypass from the load/store buffer bus.
    disp(32'h300, OpSub, 32'h0, 4'd5, 0, 32'd0, 4'd6, 1, 32'd1, 4'd0);
    bus.slb_en = 1; bus.slb_nick = 4'd6; bus.slb_dt = 32'hABCD;
    tick(); idle();
    tick();
    chk("byp_en", 32'(bus.rs_en), 32'd1);
    chk("byp_rs1", bus.rs_rs1_dt, 32'hABCD);
    tick();

    // Fill all entries waiting on nick 1, then drain in index order.
    for (int i = 0; i < 16; i++) begin
      disp(32'(i * 4), OpXor, 32'h0, 4'(i), 0, 32'd0, 4'd1, 0, 32'd0, 4'd1);
      tick();
      chk("fill_full", 32'(bus.rs_full), (i == 15) ? 32'd1 : 32'd0);
    end
    idle();
    bus.ex_en = 1; bus.ex_nick = 4'd1; bus.ex_dt = 32'h1111;
    tick(); idle();
    chk("fill_full_bc", 32'(bus.rs_full), 32'd1);
    chk("fill_no_iss", 32'(bus.rs_en), 32'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("drain_en", 32'(bus.rs_en), 32'd1);
      chk("drain_rd", 32'(bus.rs_rd_nick), 32'(k));
      chk("drain_rs2", bus.rs_rs2_dt, 32'h1111);
      if (k == 0) chk("drain_full", 32'(bus.rs_full), 32'd0);
    end
    tick();
    chk("drain_end", 32'(bus.rs_en), 32'd0);

    // Flush beats a simultaneous dispatch and wakeup.
    for (int i = 0; i < 3; i++) begin
      disp(32'h400 + 32'(i), OpOr, 32'h0, 4'(i), 0, 32'd0, 4'd9, 1, 32'd2, 4'd0);
      tick();
    end
    disp(32'h500, OpAnd, 32'h0, 4'd7, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0);
    bus.ex_en = 1; bus.ex_nick = 4'd9; bus.ex_dt = 32'h99;
    bus.rob_clr = 1;
    tick(); idle();
    chk("clr_en", 32'(bus.rs_en), 32'd0);
    chk("clr_full", 32'(bus.rs_full), 32'd0);
    bus.ex_en = 1; bus.ex_nick = 4'd9; bus.ex_dt = 32'h99;
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("clr_no_iss", 32'(bus.rs_en), 32'd0);
    end

    // Asynchronous reset while an issue is being presented.
    disp(32'h600, OpAdd, 32'h0, 4'd7, 1, 32'd3, 4'd0, 1, 32'd4, 4'd0);
    tick(); idle();
    tick();
    chk("pre_rst_en", 32'(bus.rs_en), 32'd1);
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_en", 32'(bus.rs_en), 32'd0);
    chk("rst_full", 32'(bus.rs_full), 32'd0);
    tick();
    rst_ni = 1'b1;

    // rdy low freezes a ready entry in place.
    disp(32'h700, OpSlt, 32'h0, 4'd8, 1, 32'd6, 4'd0, 1, 32'd9, 4'd0);
    tick(); idle();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_en", 32'(bus.rs_en), 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("frz_en_go", 32'(bus.rs_en), 32'd1);
    chk("frz_rd", 32'(bus.rs_rd_nick), 32'd8);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      if (!m_full() && $urandom_range(0, 1) == 1)
        disp($urandom, 6'($urandom_range(0, 27)), $urandom, 4'($urandom),
             $urandom_range(0, 2) == 0, $urandom, 4'($urandom_range(0, 7)),
             $urandom_range(0, 2) == 0, $urandom, 4'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) < 3) begin
        bus.ex_en = 1; bus.ex_nick = 4'($urandom_range(0, 7)); bus.ex_dt = $urandom;
      end
      if ($urandom_range(0, 9) < 3) begin
        bus.slb_en = 1; bus.slb_nick = 4'($urandom_range(0, 7)); bus.slb_dt = $urandom;
      end
      bus.rob_clr = ($urandom_range(0, 99) == 0);
      tick();
    end

    idle();
    rdy = 1'b1;
    tick();
    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station that sends operand-complete ALU/branch micro-ops into the execute unit over the iRS_* interface.
- Accepts renamed instructions from dispatch.
- Snoops the two result broadcast buses (execute and store/load buffer) to wake up waiting operands.
- Issues at most one ready entry per cycle.
- Sits between dispatch/ROB allocation and the execute stage; flushed by the ROB on misprediction.

Parameters:
- RS_SIZE, 16, number of entries
- IDX_W, 4, log2(RS_SIZE)
- NICK_W, 4, ROB tag (nick) width
- DATA_W, 32, operand/result width
- OP_W, 6, internal opcode width (same encoding as the execute unit)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; state frozen when low
- iDP_en  in  1  dispatch valid
- iDP_pc  in  32  instruction pc
- iDP_op  in  OP_W  opcode
- iDP_imm  in  32  sign-extended immediate
- iDP_rd_nick  in  NICK_W  destination ROB tag
- iDP_rs1_rdy  in  1  rs1 value valid
- iDP_rs1_dt  in  DATA_W  rs1 value
- iDP_rs1_nick  in  NICK_W  rs1 producer tag
- iDP_rs2_rdy  in  1  rs2 value valid
- iDP_rs2_dt  in  DATA_W  rs2 value
- iDP_rs2_nick  in  NICK_W  rs2 producer tag
- oRS_full  out  1  no free entry; dispatch must not assert iDP_en
- iEX_en  in  1  execute result broadcast valid
- iEX_nick  in  NICK_W  execute result tag
- iEX_dt  in  DATA_W  execute result data
- iSLB_en  in  1  load/store buffer result broadcast valid
- iSLB_nick  in  NICK_W  load/store buffer result tag
- iSLB_dt  in  DATA_W  load/store buffer result data
- iROB_clr  in  1  flush on misprediction
- oRS_en  out  1  issue valid to execute
- oRS_pc  out  32  issued pc
- oRS_op  out  OP_W  issued opcode
- oRS_imm  out  32  issued immediate
- oRS_rd_nick  out  NICK_W  issued destination tag
- oRS_rs1_dt  out  DATA_W  issued rs1 value
- oRS_rs2_dt  out  DATA_W  issued rs2 value

Behaviour:

Reset and global control
- rst low (asynchronous): all busy bits cleared; every output register 0, including oRS_en; oRS_full=0.
- rdy low: no entry, output or register changes. oRS_en holds its value; execute is also gated by rdy, so no double issue results.
- Per-entry state: busy, pc, op, imm, rd_nick, q1_rdy, v1, q1_nick, q2_rdy, v2, q2_nick.

Dispatch
- On iDP_en && !oRS_full, write the lowest-index non-busy entry; set busy.
- Same-cycle bypass: if an operand is not ready and its nick matches a valid broadcast this cycle, capture that data and mark the operand ready.
- Dispatch while full is ignored (protocol violation; the bench asserts it never happens).

Wakeup
- Every cycle, each busy entry with a not-ready operand compares its tag against iEX and iSLB.
- On a match, latch the data and set ready.
- If both buses carry the same tag, iEX data wins.

Issue
- Select the lowest-index entry that is busy with q1_rdy && q2_rdy, using registered state at the start of the cycle.
- At the clock edge: register fields onto oRS_*, set oRS_en=1, clear that entry's busy.
- No ready entry: oRS_en<=0; the other oRS_* outputs hold.
- One issue per cycle, maximum.

Latency
- Dispatch with both operands ready at edge N gives oRS_en=1 after edge N+1.
- Broadcast waking the last operand at edge N gives issue after edge N+1.

Full flag
- oRS_full = all entries busy, from registered state.
- A slot freed by issue becomes usable the next cycle.

Flush
- iROB_clr (sampled with rdy) clears all busy bits and sets oRS_en<=0.
- Flush overrides a simultaneous dispatch, issue and wakeup.

Width rules
- Values are stored unchanged; no arithmetic in this block.

Decomposition:
- config.v holds the shared defines: AddrBus, DataBus, ImmBus, OpBus, NickBus, RS_SIZE, RS_IDX_W, and the opcode defines.
- One natural combinational sub-module, rs_select: takes busy[RS_SIZE] and ready[RS_SIZE], and returns the lowest free index + valid, and the lowest ready index + valid.

Test Plan:
- Reset then dispatch ADD (pc=0x100, rs1=5, rs2=7, both ready, rd_nick=3) → next cycle oRS_en=1, op=ADD, rs1_dt=5, rs2_dt=7, rd_nick=3, pc=0x100; one cycle later oRS_en=0.
- Dispatch BEQ with rs1 waiting on nick 2; two cycles later iEX_en=1, nick=2, dt=0x55 → issue the following cycle with rs1_dt=0x55; no issue before that.
- Dispatch an entry waiting on nick 6 in the same cycle as iSLB broadcasting nick 6, dt=0xABCD → captured via bypass, issued next cycle with 0xABCD.
- Fill 16 entries, all waiting on nick 1 → oRS_full=1. Broadcast nick 1 → entries issue in index order 0..15 on consecutive cycles; oRS_full drops the cycle after the first issue.
- Dispatch 3 waiting entries, then assert iROB_clr together with a dispatch and a matching broadcast → oRS_en=0 next cycle, oRS_full=0, no later issue.
- Assert rst mid-issue (oRS_en=1) → oRS_en=0 immediately, no busy entries; hold rdy=0 with ready entries → no issue until rdy=1.
